dcache_controller: RTL

Direct-mapped, write-back, write-allocate data cache controller between the CPU's MEM stage and the off-chip data memory. It services 32-bit loads and stores from the pipeline in zero extra cycles on a hit. On a miss it stalls the whole pipeline while it writes back a dirty victim and refills a 256-bit line over a request/acknowledge memory interface.

---
 rtl/dcache_controller_if.sv | 25 ++
 rtl/dcache_controller.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dcache_controller_if.sv
// rtl/dcache_controller_if.sv - CPU MEM-stage and line-memory signals of the data cache.
interface dcache_controller_if;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate data cache controller.
// Define DCACHE_STATS_EN to add hit_cnt_o / miss_cnt_o counters.
module dcache_controller #(
  parameter int NUM_LINES = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  dcache_controller_if.slave  bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o
`endif
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - 5 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_e;

  state_e               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [255:0]         line_q [NUM_LINES];
  logic [IDX_W-1:0]     idx, miss_idx_q;
  logic [TAG_W-1:0]     tag, miss_tag_q;
  logic [2:0]           word;
  logic                 hit, stall_raw, store_hit, miss_start, install;
  logic                 mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [255:0]         mem_data_q, mem_data_d;
  logic                 unused_addr_bits;

  assign idx  = bus.cpu_addr_i[IDX_W+4:5];
  assign tag  = bus.cpu_addr_i[31:IDX_W+5];
  assign word = bus.cpu_addr_i[4:2];
  assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign stall_raw = (state_q != IDLE) || (bus.cpu_req_i && !hit);

  // Outputs are forced quiet while reset is held, independent of the clock.
  assign bus.cpu_stall_o = rst_i && stall_raw;
  assign bus.cpu_data_o  = (rst_i && bus.cpu_req_i && !bus.cpu_we_i && !stall_raw)
                         ? line_q[idx][{word, 5'b0} +: 32] : '0;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_data_o  = mem_data_q;

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    store_hit  = 1'b0;
    miss_start = 1'b0;
    install    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req_i) begin
          if (hit) begin
            store_hit = bus.cpu_we_i;
          end else begin
            miss_start = 1'b1;
            mem_req_d  = 1'b1;
            if (valid_q[idx] && dirty_q[idx]) begin
              state_d    = WRITEBACK;
              mem_we_d   = 1'b1;
              mem_addr_d = {tag_q[idx], idx, 5'b0};
              mem_data_d = line_q[idx];
            end else begin
              state_d    = ALLOCATE;
              mem_we_d   = 1'b0;
              mem_addr_d = {tag, idx, 5'b0};
            end
          end
        end
      end
      WRITEBACK: begin
        if (bus.mem_ack_i) begin
          state_d    = ALLOCATE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_addr_d = '0;
          mem_data_d = '0;
        end
      end
      ALLOCATE: begin
        // After a write-back the fetch request is raised one cycle after the ack.
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_addr_d = {miss_tag_q, miss_idx_q, 5'b0};
        end else if (bus.mem_ack_i) begin
          install    = 1'b1;
          state_d    = REFILL;
          mem_req_d  = 1'b0;
          mem_addr_d = '0;
        end
      end
      REFILL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      if (miss_start) begin
        miss_idx_q <= idx;
        miss_tag_q <= tag;
      end
      if (install) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (install) begin
      line_q[miss_idx_q] <= bus.mem_data_i;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end else if (store_hit) begin
      line_q[idx][{word, 5'b0} +: 32] <= bus.cpu_data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic replay_q;

  // The replay of a just-refilled request is part of its miss, not a hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      replay_q   <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      replay_q <= (state_q == REFILL);
      if (miss_start) miss_cnt_o <= miss_cnt_o + 32'd1;
      if (state_q == IDLE && bus.cpu_req_i && hit && !replay_q) hit_cnt_o <= hit_cnt_o + 32'd1;
    end
  end
`endif
endmodule
